// File: rtl/seqmux_n_pkg.sv
// ============================================================================
// Module      : seqmux_n_pkg
// Description : Shared definitions for the seqmux_n pattern sequencer
//               (sequencer state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seqmux_n_pkg;

    // Sequencer states; encoding fixed so it matches external documentation.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : seqmux_n_pkg

`default_nettype wire

// File: rtl/seqmux_n_prescaler_tick.sv
// ============================================================================
// Module      : prescaler_tick
// Description : NP-bit free-running prescaler. Emits a one-cycle tick when the
//               count is at its maximum while enabled, and wraps to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prescaler_tick #(
    parameter int NP = 22
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic tick
);

    logic [NP-1:0] r_cnt;

    // The tick is qualified by en so a paused counter sitting at max never fires.
    assign tick = en && (r_cnt == {NP{1'b1}});

    // Count while enabled; clear has priority; natural overflow wraps to 0 on tick.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + NP'(1);
        end
    end

endmodule : prescaler_tick

`default_nettype wire

// File: rtl/seqmux_n.sv
// ============================================================================
// Module      : seqmux_n
// Description : Parametrised N-state pattern sequencer. A prescaled tick steps
//               an index up or down through N stored W-bit patterns, in loop
//               or one-shot mode, with pause and restart control. The selected
//               pattern is driven from a register alongside its index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seqmux_n
    import seqmux_n_pkg::*;
#(
    parameter int             W       = 4,
    parameter int             N       = 4,
    parameter int             NP      = 22,
    parameter logic [N*W-1:0] PATTERN = 16'h8421,
    parameter bit             AUTORUN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 dir,
    input  logic                 oneshot,
    input  logic                 start,
    output logic [W-1:0]         data,
    output logic [$clog2(N)-1:0] sel,
    output logic                 wrap,
    output logic                 busy
);

    localparam int             SW     = $clog2(N);
    localparam logic [SW-1:0]  c_LAST = SW'(N - 1);

    state_t        r_state;
    logic [SW-1:0] r_sel;
    logic [W-1:0]  r_data;
    logic          r_wrap;
    logic          r_busy;

    state_t        w_state_nxt;
    logic [SW-1:0] w_sel_nxt;
    logic [W-1:0]  w_data_nxt;
    logic          w_wrap_nxt;
    logic          w_run;
    logic          w_tick;
    logic [SW-1:0] w_first;
    logic [SW-1:0] w_last;

    assign w_run   = (r_state == ST_RUN);
    assign w_first = dir ? c_LAST : '0;
    assign w_last  = dir ? '0     : c_LAST;

    // Prescaler only runs in RUN; a start (or any non-RUN state) pins it at zero.
    prescaler_tick #(
        .NP (NP)
    ) u_prescaler (
        .clk  (clk),
        .rstn (rstn),
        .clr  (start || !w_run),
        .en   (en && w_run),
        .tick (w_tick)
    );

    // Next state / index decision; start beats a coincident tick.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_wrap_nxt  = 1'b0;
        if (start) begin
            w_state_nxt = ST_RUN;
            w_sel_nxt   = w_first;
        end else if (w_run && w_tick) begin
            if (r_sel != w_last) begin
                w_sel_nxt = dir ? (r_sel - SW'(1)) : (r_sel + SW'(1));
            end else if (!oneshot) begin
                w_sel_nxt  = w_first;
                w_wrap_nxt = 1'b1;
            end else begin
                w_state_nxt = ST_DONE;
                w_wrap_nxt  = 1'b1;
            end
        end
    end

    // Pattern lookup for the next index, so data and sel register together.
    always_comb begin
        w_data_nxt = PATTERN[W-1:0];
        for (int i = 0; i < N; i++) begin
            if (w_sel_nxt == SW'(i)) begin
                w_data_nxt = PATTERN[i*W +: W];
            end
        end
    end

    // FSM state and all registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= AUTORUN ? ST_RUN : ST_IDLE;
            r_sel   <= '0;
            r_data  <= PATTERN[W-1:0];
            r_wrap  <= 1'b0;
            r_busy  <= AUTORUN;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_data  <= w_data_nxt;
            r_wrap  <= w_wrap_nxt;
            r_busy  <= (w_state_nxt == ST_RUN);
        end
    end

    assign data = r_data;
    assign sel  = r_sel;
    assign wrap = r_wrap;
    assign busy = r_busy;

endmodule : seqmux_n

`default_nettype wire

// File: tb/tb_seqmux_n.sv
// ============================================================================
// Module      : tb_seqmux_n
// Description : Self-checking bench for seqmux_n. Three instances (default
//               autorun, idle-at-reset one-shot set-up, and a W=8/N=5/NP=2
//               sweep) share one stimulus stream; each is compared every cycle
//               against a behavioural model of the sequencing rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seqmux_n;

    logic clk     = 1'b0;
    logic rstn    = 1'b0;
    logic en      = 1'b1;
    logic dir     = 1'b0;
    logic oneshot = 1'b0;
    logic start   = 1'b0;

    logic [3:0] a_data, b_data;
    logic [1:0] a_sel,  b_sel;
    logic       a_wrap, b_wrap, a_busy, b_busy;
    logic [7:0] c_data;
    logic [2:0] c_sel;
    logic       c_wrap, c_busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seqmux_n #(.W(4), .N(4), .NP(1), .PATTERN(16'h8421), .AUTORUN(1'b1)) dut_a (
        .clk(clk), .rstn(rstn), .en(en), .dir(dir), .oneshot(oneshot), .start(start),
        .data(a_data), .sel(a_sel), .wrap(a_wrap), .busy(a_busy));

    seqmux_n #(.W(4), .N(4), .NP(1), .PATTERN(16'h8421), .AUTORUN(1'b0)) dut_b (
        .clk(clk), .rstn(rstn), .en(en), .dir(dir), .oneshot(oneshot), .start(start),
        .data(b_data), .sel(b_sel), .wrap(b_wrap), .busy(b_busy));

    seqmux_n #(.W(8), .N(5), .NP(2), .PATTERN(40'hA5_3C_81_7E_11), .AUTORUN(1'b1)) dut_c (
        .clk(clk), .rstn(rstn), .en(en), .dir(dir), .oneshot(oneshot), .start(start),
        .data(c_data), .sel(c_sel), .wrap(c_wrap), .busy(c_busy));

    // ---------------- behavioural reference model ----------------
    // m_st: 0 idle, 1 run, 2 done. m_cnt counts running cycles since last step.
    int m_st  [3];
    int m_idx [3];
    int m_cnt [3];
    bit m_wrap[3];

    function automatic int n_of(int k);
        return (k == 2) ? 5 : 4;
    endfunction

    function automatic int period_of(int k);
        return (k == 2) ? 4 : 2;
    endfunction

    function automatic bit autorun_of(int k);
        return (k != 1);
    endfunction

    function automatic int pat(int k, int i);
        if (k < 2) return 1 << i;
        case (i)
            0: return 'h11;
            1: return 'h7E;
            2: return 'h81;
            3: return 'h3C;
            default: return 'hA5;
        endcase
    endfunction

    always @(posedge clk or negedge rstn) begin
        for (int k = 0; k < 3; k++) begin
            int n;
            int first;
            int last;
            n     = n_of(k);
            first = dir ? n - 1 : 0;
            last  = dir ? 0 : n - 1;
            if (!rstn) begin
                m_st[k]   = autorun_of(k) ? 1 : 0;
                m_idx[k]  = 0;
                m_cnt[k]  = 0;
                m_wrap[k] = 1'b0;
            end else begin
                m_wrap[k] = 1'b0;
                if (start) begin
                    m_st[k]  = 1;
                    m_idx[k] = first;
                    m_cnt[k] = 0;
                end else if (m_st[k] == 1 && en) begin
                    m_cnt[k] = m_cnt[k] + 1;
                    if (m_cnt[k] == period_of(k)) begin
                        m_cnt[k] = 0;
                        if (m_idx[k] != last) begin
                            m_idx[k] = (m_idx[k] + (dir ? n - 1 : 1)) % n;
                        end else if (!oneshot) begin
                            m_idx[k]  = first;
                            m_wrap[k] = 1'b1;
                        end else begin
                            m_st[k]   = 2;
                            m_wrap[k] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            logic [31:0] s;
            logic [31:0] d;
            logic        w;
            logic        b;
            case (k)
                0:       begin s = 32'(a_sel); d = 32'(a_data); w = a_wrap; b = a_busy; end
                1:       begin s = 32'(b_sel); d = 32'(b_data); w = b_wrap; b = b_busy; end
                default: begin s = 32'(c_sel); d = 32'(c_data); w = c_wrap; b = c_busy; end
            endcase
            chk({tag, ".sel"},  k, s, 32'(m_idx[k]));
            chk({tag, ".data"}, k, d, 32'(pat(k, m_idx[k])));
            chk({tag, ".wrap"}, k, 32'(w), 32'(m_wrap[k]));
            chk({tag, ".busy"}, k, 32'(b), 32'(m_st[k] == 1));
        end
    endtask

    task automatic run_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_all(tag);
        end
    endtask

    task automatic pulse_start(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_all(tag);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        bit found;

        // Reset values (held low across edges).
        repeat (2) @(negedge clk);
        chk("rst.a_sel",  0, 32'(a_sel),  32'd0);
        chk("rst.a_data", 0, 32'(a_data), 32'd1);
        chk("rst.a_wrap", 0, 32'(a_wrap), 32'd0);
        chk("rst.a_busy", 0, 32'(a_busy), 32'd1);
        chk("rst.b_busy", 1, 32'(b_busy), 32'd0);
        chk("rst.c_data", 2, 32'(c_data), 32'h11);
        check_all("rst");
        rstn = 1'b1;

        // Free run upward, loop mode.
        run_cycles(20, "up");

        // Down direction after restart.
        dir = 1'b1;
        pulse_start("down_start");
        chk("down_first.a", 0, 32'(a_data), 32'd8);
        run_cycles(20, "down");

        // One-shot pass, then replay.
        dir = 1'b0;
        oneshot = 1'b1;
        pulse_start("os_start");
        run_cycles(24, "oneshot");
        chk("os_done.b_data", 1, 32'(b_data), 32'd8);
        chk("os_done.b_busy", 1, 32'(b_busy), 32'd0);
        oneshot = 1'b0;
        run_cycles(3, "os_hold");
        pulse_start("os_replay");
        chk("os_replay.b_data", 1, 32'(b_data), 32'd1);
        run_cycles(6, "os_replay_run");

        // Pause mid-pass.
        pulse_start("pause_start");
        run_cycles(3, "pre_pause");
        en = 1'b0;
        run_cycles(5, "paused");
        en = 1'b1;
        run_cycles(12, "resume");

        // Restart coincident with a step out of index 2 on dut_a.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            check_all("seek");
            if (m_idx[0] == 2 && m_cnt[0] == 1) found = 1'b1;
        end
        chk("seek_bound", 0, 32'(found), 32'd1);
        pulse_start("restart_on_tick");
        chk("restart_on_tick.a_sel", 0, 32'(a_sel), 32'd0);
        run_cycles(5, "after_restart");

        // Asynchronous reset between edges.
        #1 rstn = 1'b0;
        #1;
        chk("async_rst.a_sel",  0, 32'(a_sel),  32'd0);
        chk("async_rst.a_data", 0, 32'(a_data), 32'd1);
        chk("async_rst.a_wrap", 0, 32'(a_wrap), 32'd0);
        check_all("async_rst");
        @(negedge clk);
        rstn = 1'b1;
        run_cycles(12, "post_rst");

        // Randomized phase.
        for (int i = 0; i < 400; i++) begin
            en      = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            if ($urandom_range(0, 31) == 0) oneshot = ~oneshot;
            start   = ($urandom_range(0, 39) == 0);
            @(negedge clk);
            start = 1'b0;
            check_all("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule : tb_seqmux_n

`default_nettype wire
